// File: rtl/halftone_pkg.sv
// Shared constants for the 4x4 ordered-dither halftoner: Bayer matrix,
// threshold scaling and default colours.
package halftone_pkg;

  localparam int unsigned THR_STEP   = 128;
  localparam int unsigned THR_OFFSET = 64;

  localparam logic [23:0] DEF_ON_COLOR  = 24'hFFFFFF;
  localparam logic [23:0] DEF_OFF_COLOR = 24'h000000;

  // Indexed [y][x]
  localparam logic [3:0] BAYER [0:3][0:3] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  function automatic logic [10:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
    return 11'(BAYER[y][x]) * 11'(THR_STEP) + 11'(THR_OFFSET);
  endfunction

endpackage

// File: rtl/halftone_threshold.sv
// Combinational dot decision for one pixel; HALFTONE_INVERT_EN flips polarity.
// Zero latency, no flow control.
module halftone_threshold
  import halftone_pkg::*;
(
  input  logic [1:0]  x_lo,
  input  logic [1:0]  y,
  input  logic [10:0] sum,
  output logic        dot
);

  logic [10:0] thr;

  always_comb begin
    thr = bayer_thr(y, x_lo);
`ifdef HALFTONE_INVERT_EN
    dot = (sum < thr);
`else
    dot = (sum >= thr);
`endif
  end

endmodule

// File: rtl/halftone.sv
// 4x4 Bayer halftoner with raster tracking (HALFTONE_INVERT_EN = ink polarity).
// 1-clock registered latency; no backpressure, one pixel accepted per clock.
module halftone
  import halftone_pkg::*;
#(
  parameter int          LINE_WIDTH = 640,
  parameter logic [23:0] ON_COLOR   = DEF_ON_COLOR,
  parameter logic [23:0] OFF_COLOR  = DEF_OFF_COLOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] sum,
  input  logic        newFrame,
  output logic [23:0] htPixel,
  output logic        ready
);

  localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [XW-1:0] LAST_X = XW'(LINE_WIDTH - 1);

  logic [XW-1:0] x_q, x_d, pos_x;
  logic [1:0]    y_q, y_d, pos_y;
  logic          running_q, running_d;
  logic          ready_q, ready_d;
  logic [23:0]   ht_pixel_q, ht_pixel_d;
  logic          advance;
  logic          dot;

  halftone_threshold u_thr (
    .x_lo (pos_x[1:0]),
    .y    (pos_y),
    .sum  (sum),
    .dot  (dot)
  );

  always_comb begin
    // A newFrame pulse restarts the raster in the same cycle it arrives.
    pos_x      = newFrame ? '0 : x_q;
    pos_y      = newFrame ? '0 : y_q;
    advance    = running_q | newFrame;
    x_d        = x_q;
    y_d        = y_q;
    running_d  = running_q | newFrame;
    ready_d    = advance;
    ht_pixel_d = ht_pixel_q;
    if (advance) begin
      ht_pixel_d = dot ? ON_COLOR : OFF_COLOR;
      if (pos_x == LAST_X) begin
        x_d = '0;
        y_d = pos_y + 2'd1;
      end else begin
        x_d = pos_x + XW'(1);
        y_d = pos_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      running_q  <= 1'b0;
      ready_q    <= 1'b0;
      ht_pixel_q <= OFF_COLOR;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      running_q  <= running_d;
      ready_q    <= ready_d;
      ht_pixel_q <= ht_pixel_d;
    end
  end

  assign htPixel = ht_pixel_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_halftone.sv
// Directed bench for halftone: raster tracking, Bayer thresholds, restart and reset priority.
module tb_halftone;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] sum = '0;
  logic        newFrame = 1'b0;
  logic [23:0] htPixel;
  logic        ready;

  int total = 0;
  int bad   = 0;

  localparam logic [23:0] ON  = 24'hFFFFFF;
  localparam logic [23:0] OFF = 24'h000000;

  halftone #(.LINE_WIDTH(640)) dut (
    .clk      (clk),
    .reset    (reset),
    .sum      (sum),
    .newFrame (newFrame),
    .htPixel  (htPixel),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one pixel's inputs, clock it, and leave outputs settled for checking.
  task automatic cyc(input logic r, input logic nf, input logic [10:0] s);
    reset    = r;
    newFrame = nf;
    sum      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input logic nf, input logic [10:0] s,
                     input logic [23:0] exp);
    cyc(1'b0, nf, s);
    chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    chk(tag, {8'd0, htPixel}, {8'd0, exp});
  endtask

  task automatic fill(input int n, input logic [10:0] s);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, s);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 11'd2047);
      chk("rst_rdy", {31'd0, ready}, 32'd0);
      chk("rst_pix", {8'd0, htPixel}, {8'd0, OFF});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 11'd2047);
      chk("idle_rdy", {31'd0, ready}, 32'd0);
      chk("idle_pix", {8'd0, htPixel}, {8'd0, OFF});
    end

    // Row 0, x 0..3 with bright input
    pix("r0x0_1900", 1'b1, 11'd1900, ON);
    pix("r0x1_1900", 1'b0, 11'd1900, ON);
    pix("r0x2_1900", 1'b0, 11'd1900, ON);
    pix("r0x3_1900", 1'b0, 11'd1900, ON);
    // Row 0, x 4..7 (x mod 4 = 0..3), T = 64,1088,320,1344
    pix("r0x4_300", 1'b0, 11'd300, ON);
    pix("r0x5_300", 1'b0, 11'd300, OFF);
    pix("r0x6_300", 1'b0, 11'd300, OFF);
    pix("r0x7_300", 1'b0, 11'd300, OFF);

    fill(632 + 640, 11'd0);
    pix("r2x0_0", 1'b0, 11'd0, OFF);
    pix("r2x1_0", 1'b0, 11'd0, OFF);
    pix("r2x2_300", 1'b0, 11'd300, ON);
    pix("r2x3_300", 1'b0, 11'd300, OFF);

    fill(636, 11'd0);
    pix("r3x0_1900", 1'b0, 11'd1900, OFF);
    fill(639, 11'd0);
    // y wrapped back to row 0: T = 64, 1088, 320
    pix("r0x0_63", 1'b0, 11'd63, OFF);
    pix("r0x1_1088", 1'b0, 11'd1088, ON);
    pix("r0x2_319", 1'b0, 11'd319, OFF);
    fill(637 + 1280, 11'd0);
    pix("r3x0_2047", 1'b0, 11'd2047, ON);

    // Restart at row 3, x = 37
    fill(36, 11'd0);
    pix("restart_x37", 1'b1, 11'd64, ON);
    pix("restart_x1", 1'b0, 11'd1100, ON);
    pix("restart_x2", 1'b0, 11'd320, ON);

    // Reset wins over a simultaneous newFrame
    cyc(1'b1, 1'b1, 11'd2047);
    chk("rstnf_rdy", {31'd0, ready}, 32'd0);
    chk("rstnf_pix", {8'd0, htPixel}, {8'd0, OFF});
    cyc(1'b0, 1'b0, 11'd2047);
    chk("rstnf_idle_rdy", {31'd0, ready}, 32'd0);
    chk("rstnf_idle_pix", {8'd0, htPixel}, {8'd0, OFF});
    pix("post_x0", 1'b1, 11'd64, ON);
    pix("post_x1", 1'b0, 11'd1100, ON);
    pix("post_x2", 1'b0, 11'd319, OFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/halftone.md
Name: halftone

Overview:
- Converts a per-pixel intensity stream into a 1-bit ordered-dither (4x4 Bayer) halftone, expanded to 24-bit RGB (black/white).
- Sits between the pixel-sum stage, which supplies an 11-bit intensity each clock, and the frame-buffer/display writer.
- Tracks its own raster position: one pixel per clock, restarting at each newFrame pulse.

Parameters:
- LINE_WIDTH, 640, pixels per line; the x counter wraps at LINE_WIDTH-1.
- ON_COLOR, 24'hFFFFFF, htPixel value when a dot is "on".
- OFF_COLOR, 24'h000000, htPixel value when a dot is "off".

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sum  in  11  pixel intensity, 0 (dark) to 2047 (bright); sampled every clock.
- newFrame  in  1  one-cycle pulse; the pixel on sum in this cycle is pixel (0,0) of a new frame.
- htPixel  out  24  registered halftoned pixel colour.
- ready  out  1  high while htPixel carries a valid frame pixel.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- State: x counter (ceil(log2 LINE_WIDTH) bits), y counter (2 bits, mod 4), running flag.
- Reset values: htPixel = OFF_COLOR, ready = 0, x = 0, y = 0, running = 0. Reset has priority over newFrame in the same cycle.
- Position used for the current cycle's sum:
  - If newFrame = 1: (0,0).
  - Otherwise: the current (x, y).
- Position update each clock when running or newFrame:
  - next x = pos_x + 1, wrapping to 0 after LINE_WIDTH-1.
  - On x wrap, y increments mod 4.
  - newFrame sets running = 1.
- Cycles before the first newFrame after reset: counters hold, ready stays 0.
- Bayer value b = B[y][x mod 4], with rows:
  - y0: 0 8 2 10
  - y1: 12 4 14 6
  - y2: 3 11 1 9
  - y3: 15 7 13 5
- Threshold T = b*128 + 64, range 64..1984, 11-bit unsigned.
- Dot on iff sum >= T (unsigned compare). Consequences:
  - sum = 0 is always off.
  - sum >= 1984 is always on.
  - Density is approximately sum/2048.
- Latency 1 clock: htPixel and ready are registered. ready(t+1) = running or newFrame at t. htPixel(t+1) = ON_COLOR or OFF_COLOR per sum(t).
- Once set, ready stays 1 until reset.
- newFrame mid-line/mid-frame: immediate restart at (0,0) in that cycle; no extra bubble.
- No input backpressure: exactly one pixel accepted per clock while running.

Optional Feature:
- Macro HALFTONE_INVERT_EN.
- Defined: the on/off decision is inverted (dot on iff sum < T), giving ink-style output where bright input yields OFF_COLOR.
- Not defined: normal polarity as above.
- Latency and ready are identical in both builds.

Decomposition:
- Shared package halftone_pkg:
  - Bayer 4x4 constant array.
  - Threshold step (128) and offset (64) constants.
  - Default ON/OFF colour constants.
- One natural sub-module, halftone_threshold: purely combinational; (x[1:0], y[1:0], sum) -> dot bit. The top level keeps the counters and output registers.

Test Plan:
- Reset held 3 clocks, then released with no newFrame -> ready = 0, htPixel = 24'h000000 throughout.
- newFrame pulse with sum = 1900, held for 4 clocks, row 0 -> ready = 1 from the next clock; htPixel = FFFFFF for x = 0..3 (max row-0 T = 1344).
- sum = 300, row 0, x = 0..3 -> FFFFFF, 000000, 000000, 000000. Row 2, x = 2 (b = 1, T = 192) -> FFFFFF.
- sum = 1900 through a full line wrap to row 3, x = 0 (b = 15, T = 1984) -> 000000. sum = 2047 at the same position -> FFFFFF.
- newFrame reasserted mid-line at x = 37 -> the pixel in that cycle uses b = 0; the following pixel uses x = 1.
- reset and newFrame asserted together -> reset wins: ready = 0, counters 0, running stays 0.
